// File: rtl/alu_issue_controller_pkg.sv
// Shared types and constants for the ALU issue controller.
// The optional SLT decode is enabled by defining ALU_SLT_EN.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b110,
    OP_SHL1 = 3'b100,
    OP_SHR1 = 3'b101
  } alu_op_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ILL   = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLL = 6'b000000;
  localparam logic [5:0] FUNCT_SRL = 6'b000010;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } ctl_state_e;

  localparam int unsigned ALU_LATENCY_MAX = 15;
  localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/alu_issue_controller_if.sv
// Request/response handshake bundle between the control unit and the issue controller.
// slave = controller side, master = requester/consumer side.
interface alu_issue_controller_if;

  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_aluop;
  logic [5:0]  req_funct;
  logic [31:0] req_a;
  logic [31:0] req_b;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic        resp_zero;
  logic        resp_overflow;
  logic        resp_err;

  modport slave (
    input  req_valid, req_aluop, req_funct, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_result, resp_zero, resp_overflow, resp_err
  );

  modport master (
    output req_valid, req_aluop, req_funct, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_zero, resp_overflow, resp_err
  );

endinterface

// File: rtl/alu_issue_controller_decoder.sv
// Combinational (ALUOp, funct) -> ALU op code decoder.
// SLT (funct 101010) is only legal when ALU_SLT_EN is defined.
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output alu_op_e    alu_op_o,
  output logic       is_slt_o,
  output logic       illegal_o
);

  always_comb begin
    alu_op_o  = OP_ADD;
    is_slt_o  = 1'b0;
    illegal_o = 1'b0;
    case (aluop_i)
      ALUOP_ADD: alu_op_o = OP_ADD;
      ALUOP_SUB: alu_op_o = OP_SUB;
      ALUOP_RTYPE: begin
        case (funct_i)
          FUNCT_ADD: alu_op_o = OP_ADD;
          FUNCT_SUB: alu_op_o = OP_SUB;
          FUNCT_AND: alu_op_o = OP_AND;
          FUNCT_OR:  alu_op_o = OP_OR;
          FUNCT_SLL: alu_op_o = OP_SHL1;
          FUNCT_SRL: alu_op_o = OP_SHR1;
`ifdef ALU_SLT_EN
          FUNCT_SLT: begin
            alu_op_o = OP_SUB;
            is_slt_o = 1'b1;
          end
`endif
          default:   illegal_o = 1'b1;
        endcase
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_controller.sv
// Issues decoded requests to a fixed-latency ALU, holds its inputs, and returns the result.
// Optional SLT support is enabled by defining ALU_SLT_EN.
module alu_issue_controller
  import alu_pkg::*;
#(
  parameter int unsigned ALU_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  alu_issue_controller_if.slave   bus,
  output logic [2:0]              alu_op,
  output logic [31:0]             alu_a,
  output logic [31:0]             alu_b,
  input  logic [31:0]             alu_result,
  input  logic                    alu_zero,
  input  logic                    alu_overflow
);

  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(ALU_LATENCY);

  ctl_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  alu_op_e          alu_op_q, alu_op_d;
  logic [31:0]      alu_a_q, alu_a_d;
  logic [31:0]      alu_b_q, alu_b_d;
  logic             slt_q, slt_d;
  logic             ill_q, ill_d;
  logic [31:0]      resp_result_q, resp_result_d;
  logic             resp_zero_q, resp_zero_d;
  logic             resp_ovf_q, resp_ovf_d;
  logic             resp_err_q, resp_err_d;

  alu_op_e dec_op;
  logic    dec_slt;
  logic    dec_illegal;
  logic    slt_lt;

  alu_op_decoder u_dec (
    .aluop_i   (bus.req_aluop),
    .funct_i   (bus.req_funct),
    .alu_op_o  (dec_op),
    .is_slt_o  (dec_slt),
    .illegal_o (dec_illegal)
  );

`ifdef ALU_SLT_EN
  // Signed less-than from the held operands and the SUB result sign.
  assign slt_lt = (alu_a_q[31] != alu_b_q[31]) ? alu_a_q[31] : alu_result[31];
`else
  assign slt_lt = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      alu_op_q      <= OP_AND;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      slt_q         <= 1'b0;
      ill_q         <= 1'b0;
      resp_result_q <= '0;
      resp_zero_q   <= 1'b0;
      resp_ovf_q    <= 1'b0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      alu_op_q      <= alu_op_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      slt_q         <= slt_d;
      ill_q         <= ill_d;
      resp_result_q <= resp_result_d;
      resp_zero_q   <= resp_zero_d;
      resp_ovf_q    <= resp_ovf_d;
      resp_err_q    <= resp_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    alu_op_d      = alu_op_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    slt_d         = slt_q;
    ill_d         = ill_q;
    resp_result_d = resp_result_q;
    resp_zero_d   = resp_zero_q;
    resp_ovf_d    = resp_ovf_q;
    resp_err_d    = resp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
          ill_d   = dec_illegal;
          // Illegal requests leave the ALU inputs untouched.
          if (!dec_illegal) begin
            alu_op_d = dec_op;
            alu_a_d  = bus.req_a;
            alu_b_d  = bus.req_b;
            slt_d    = dec_slt;
          end
        end
      end

      ST_WAIT: begin
        if (ill_q) begin
          // One-cycle pass-through so an error response lands one edge after accept.
          resp_result_d = '0;
          resp_zero_d   = 1'b0;
          resp_ovf_d    = 1'b0;
          resp_err_d    = 1'b1;
          state_d       = ST_RESP;
        end else if (cnt_q == LAT_CNT) begin
          if (slt_q) begin
            resp_result_d = {31'b0, slt_lt};
            resp_zero_d   = ~slt_lt;
            resp_ovf_d    = 1'b0;
          end else begin
            resp_result_d = alu_result;
            resp_zero_d   = alu_zero;
            resp_ovf_d    = alu_overflow;
          end
          resp_err_d = 1'b0;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RESP: begin
        if (bus.resp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.req_ready     = rst_n && (state_q == ST_IDLE);
  assign bus.resp_valid    = (state_q == ST_RESP);
  assign bus.resp_result   = resp_result_q;
  assign bus.resp_zero     = resp_zero_q;
  assign bus.resp_overflow = resp_ovf_q;
  assign bus.resp_err      = resp_err_q;

  assign alu_op = alu_op_q;
  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;

endmodule

// File: tb/tb_alu_issue_controller.sv
// Directed, table-driven bench for alu_issue_controller with a 2-deep pipelined ALU model.
// Define ALU_SLT_EN to exercise the SLT vectors instead of their illegal-decode variants.
module tb_alu_issue_controller;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  alu_op;
  logic [31:0] alu_a, alu_b;
  logic [31:0] alu_result;
  logic        alu_zero, alu_overflow;

  alu_issue_controller_if bus ();

  alu_issue_controller #(.ALU_LATENCY(LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .alu_op       (alu_op),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow)
  );

  always #5 clk = ~clk;

  // ALU model: combinational function followed by two register stages.
  logic [31:0] m_res;
  logic        m_ovf;
  logic [33:0] p1 = '0, p2 = '0;

  always_comb begin
    m_res = 32'd0;
    m_ovf = 1'b0;
    case (alu_op)
      3'b000: m_res = alu_a & alu_b;
      3'b001: m_res = alu_a | alu_b;
      3'b010: begin
        m_res = alu_a + alu_b;
        m_ovf = (alu_a[31] == alu_b[31]) && (m_res[31] != alu_a[31]);
      end
      3'b110: begin
        m_res = alu_a - alu_b;
        m_ovf = (alu_a[31] != alu_b[31]) && (m_res[31] != alu_a[31]);
      end
      3'b100: m_res = alu_a << 1;
      3'b101: m_res = alu_a >> 1;
      default: m_res = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    p1 <= {m_ovf, (m_res == 32'd0), m_res};
    p2 <= p1;
  end

  assign alu_result   = p2[31:0];
  assign alu_zero     = p2[32];
  assign alu_overflow = p2[33];

  typedef struct {
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        err;
    logic [31:0] res;
    logic        z;
    logic        o;
    int          hold;
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_a = 32'd0;
  logic [31:0] last_b = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_vec(input vec_t v, input int idx);
    int n;
    logic [31:0] ea, eb;
    ea = v.err ? last_a : v.a;
    eb = v.err ? last_b : v.b;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_aluop = v.aluop;
    bus.req_funct = v.funct;
    bus.req_a     = v.a;
    bus.req_b     = v.b;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("alu_op_launch", 32'(alu_op), 32'(v.op));
    chk("alu_a_launch", alu_a, ea);
    chk("alu_b_launch", alu_b, eb);
    n = 0;
    while (!bus.resp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("resp_latency", 32'(n), v.err ? 32'd1 : 32'(LAT + 1));
    chk("resp_result", bus.resp_result, v.res);
    chk("resp_flags", {29'd0, bus.resp_err, bus.resp_zero, bus.resp_overflow},
        {29'd0, v.err, v.z, v.o});
    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk); #1;
      chk("resp_hold", {bus.resp_valid, bus.resp_err, bus.resp_zero, bus.resp_overflow,
                        bus.resp_result[27:0]},
          {1'b1, v.err, v.z, v.o, v.res[27:0]});
    end
    chk("alu_op_held", 32'(alu_op), 32'(v.op));
    chk("alu_a_held", alu_a, ea);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk("resp_valid_clear", 32'(bus.resp_valid), 32'd0);
    chk("req_ready_back", 32'(bus.req_ready), 32'd1);
    if (!v.err) begin
      last_a = v.a;
      last_b = v.b;
    end
    $display("txn %0d: aluop=%b funct=%b a=%h b=%h -> op=%b result=%h z=%b o=%b err=%b",
             idx, v.aluop, v.funct, v.a, v.b, alu_op, bus.resp_result,
             bus.resp_zero, bus.resp_overflow, bus.resp_err);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ready"}, 32'(bus.req_ready), 32'd0);
    chk({name, "_out"}, {27'd0, bus.resp_valid, bus.resp_err, bus.resp_zero,
                         bus.resp_overflow, 1'b0} | 32'(alu_op), 32'd0);
    chk({name, "_data"}, bus.resp_result | alu_a | alu_b, 32'd0);
  endtask

  vec_t vecs[13];

  initial begin
    int cnt;
    vecs[0]  = '{2'b00, 6'b000000, 32'd5,        32'd7,        3'b010, 1'b0, 32'd12,       1'b0, 1'b0, 0};
    vecs[1]  = '{2'b10, 6'b100010, 32'h1234,     32'h1234,     3'b110, 1'b0, 32'd0,        1'b1, 1'b0, 4};
    vecs[2]  = '{2'b10, 6'b100100, 32'hF0,       32'h3C,       3'b000, 1'b0, 32'h30,       1'b0, 1'b0, 0};
    vecs[3]  = '{2'b10, 6'b100101, 32'hF0,       32'h0F,       3'b001, 1'b0, 32'hFF,       1'b0, 1'b0, 0};
    vecs[4]  = '{2'b10, 6'b000000, 32'h80000001, 32'h55,       3'b100, 1'b0, 32'h2,        1'b0, 1'b0, 0};
    vecs[5]  = '{2'b10, 6'b000010, 32'h80000000, 32'h66,       3'b101, 1'b0, 32'h40000000, 1'b0, 1'b0, 0};
    vecs[6]  = '{2'b01, 6'b111111, 32'h80000000, 32'd1,        3'b110, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 0};
    vecs[7]  = '{2'b00, 6'b000000, 32'h7FFFFFFF, 32'd1,        3'b010, 1'b0, 32'h80000000, 1'b0, 1'b1, 0};
    vecs[8]  = '{2'b11, 6'b100000, 32'hDEAD,     32'hBEEF,     3'b010, 1'b1, 32'd0,        1'b0, 1'b0, 2};
    vecs[9]  = '{2'b10, 6'b111111, 32'h1111,     32'h2222,     3'b010, 1'b1, 32'd0,        1'b0, 1'b0, 0};
    vecs[10] = '{2'b10, 6'b100000, 32'hFFFFFFFF, 32'd1,        3'b010, 1'b0, 32'd0,        1'b1, 1'b0, 0};
`ifdef ALU_SLT_EN
    vecs[11] = '{2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1,        3'b110, 1'b0, 32'd1,        1'b0, 1'b0, 0};
    vecs[12] = '{2'b10, 6'b101010, 32'd3,        32'd2,        3'b110, 1'b0, 32'd0,        1'b1, 1'b0, 0};
`else
    vecs[11] = '{2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1,        3'b010, 1'b1, 32'd0,        1'b0, 1'b0, 0};
    vecs[12] = '{2'b10, 6'b101010, 32'd3,        32'd2,        3'b010, 1'b1, 32'd0,        1'b0, 1'b0, 0};
`endif

    bus.req_valid  = 1'b0;
    bus.req_aluop  = 2'b00;
    bus.req_funct  = 6'd0;
    bus.req_a      = 32'd0;
    bus.req_b      = 32'd0;
    bus.resp_ready = 1'b0;

    #2;
    chk_all_zero("reset_state");
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("idle_req_ready", 32'(bus.req_ready), 32'd1);
    chk("idle_resp_valid", 32'(bus.resp_valid), 32'd0);

    for (int i = 0; i < 13; i++) begin
      do_vec(vecs[i], i);
    end

    // Asynchronous reset while a response is being held.
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_aluop = 2'b00;
    bus.req_a     = 32'd9;
    bus.req_b     = 32'd4;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    cnt = 0;
    while (!bus.resp_valid && cnt < 20) begin
      @(posedge clk); #1; cnt++;
    end
    chk("pre_reset_result", bus.resp_result, 32'd13);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midcycle_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("post_reset_ready", 32'(bus.req_ready), 32'd1);
    chk("post_reset_valid", 32'(bus.resp_valid), 32'd0);
    $display("txn reset_hold: async reset during RESP");

    // Reset one edge after accept: the in-flight request must vanish.
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_aluop = 2'b00;
    bus.req_a     = 32'd100;
    bus.req_b     = 32'd200;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("wait_reset_op", 32'(alu_op), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (bus.resp_valid) cnt++;
    end
    chk("no_resp_after_reset", 32'(cnt), 32'd0);
    $display("txn reset_wait: async reset during WAIT, %0d spurious responses", cnt);
    last_a = 32'd0;
    last_b = 32'd0;
    do_vec('{2'b10, 6'b100100, 32'hF0, 32'h3C, 3'b000, 1'b0, 32'h30, 1'b0, 1'b0, 0}, 99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
